// File: rtl/service_window_pkg.sv
// Shared types and default sizing for the service-window timer bank.
package service_window_pkg;

  // Per-channel window state.
  typedef enum logic {
    SW_IDLE = 1'b0,
    SW_OPEN = 1'b1
  } sw_state_e;

  localparam int SW_CH_DEF = 4;
  localparam int SW_W_DEF  = 8;

endpackage

// File: rtl/service_window_ch.sv
// One service-window timer: holds sw_stat low for the loaded length, then
// releases it with a single-cycle done pulse. Abort closes silently.
module service_window_ch
  import service_window_pkg::*;
#(
  parameter int W      = SW_W_DEF,
  parameter bit RETRIG = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] len,
  output logic         sw_stat,
  output logic         done,
  output logic [W-1:0] rem
);

  sw_state_e    state_q, state_d;
  logic [W-1:0] rem_q, rem_d;
  logic         sw_stat_q, sw_stat_d;
  logic         done_q, done_d;

  // Next-state decode: abort beats start, start (if accepted) beats countdown.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d   = state_q;
    rem_d     = rem_q;
    sw_stat_d = sw_stat_q;
    done_d    = 1'b0;
    if (abort) begin
      state_d   = SW_IDLE;
      rem_d     = '0;
      sw_stat_d = 1'b1;
    end else begin
      case (state_q)
        SW_IDLE: begin
          if (start) begin
            if (len != '0) begin
              state_d   = SW_OPEN;
              rem_d     = len;
              sw_stat_d = 1'b0;
            end else begin
              // Zero-length window: never opens, still reports completion.
              done_d = 1'b1;
            end
          end
        end
        SW_OPEN: begin
          if (start && RETRIG) begin
            if (len != '0) begin
              rem_d = len;
            end else begin
              state_d   = SW_IDLE;
              rem_d     = '0;
              sw_stat_d = 1'b1;
              done_d    = 1'b1;
            end
          end else if (rem_q == W'(1)) begin
            state_d   = SW_IDLE;
            rem_d     = '0;
            sw_stat_d = 1'b1;
            done_d    = 1'b1;
          end else begin
            // OPEN guarantees rem_q >= 1, so this never wraps.
            rem_d = rem_q - W'(1);
          end
        end
        default: begin
          state_d   = SW_IDLE;
          rem_d     = '0;
          sw_stat_d = 1'b1;
        end
      endcase
    end
  end

  // Channel state register with synchronous reset to idle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q   <= SW_IDLE;
      rem_q     <= '0;
      sw_stat_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      sw_stat_q <= sw_stat_d;
      done_q    <= done_d;
    end
  end

  assign sw_stat = sw_stat_q;
  assign done    = done_q;
  assign rem     = rem_q;

endmodule

// File: rtl/service_window_bank.sv
// Bank of CH independent service-window timers with a registered count
// read port and an any-window-open summary.
module service_window_bank
  import service_window_pkg::*;
#(
  parameter  int CH     = SW_CH_DEF,
  parameter  int W      = SW_W_DEF,
  parameter  int RETRIG = 1,
  localparam int SEL_W  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [CH-1:0]     START,
  input  logic [CH-1:0]     ABORT,
  input  logic [CH*W-1:0]   SWLEN,
  output logic [CH-1:0]     SWSTAT,
  output logic [CH-1:0]     DONE,
  output logic              ANY_OPEN,
  input  logic [SEL_W-1:0]  RDSEL,
  output logic [W-1:0]      RDCNT
);

  logic [W-1:0] rem [CH];
  logic [W-1:0] rdcnt_q, rdcnt_d;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    service_window_ch #(
      .W      (W),
      .RETRIG (RETRIG != 0)
    ) u_ch (
      .clk     (CLK),
      .rst     (RST),
      .start   (START[i]),
      .abort   (ABORT[i]),
      .len     (SWLEN[i*W +: W]),
      .sw_stat (SWSTAT[i]),
      .done    (DONE[i]),
      .rem     (rem[i])
    );
  end

  // Read mux: out-of-range selects fall through to zero.
  always_comb begin
    rdcnt_d = '0;
    for (int i = 0; i < CH; i++) begin
      if (RDSEL == SEL_W'(i)) rdcnt_d = rem[i];
    end
  end

  // Registered count read port.
  always_ff @(posedge CLK) begin
    if (RST) rdcnt_q <= '0;
    else     rdcnt_q <= rdcnt_d;
  end

  assign RDCNT    = rdcnt_q;
  assign ANY_OPEN = ~&SWSTAT;

endmodule

// File: tb/tb_service_window_bank.sv
// Self-checking bench: two banks (RETRIG=1 and RETRIG=0) share stimulus and
// are compared against a behavioural remaining-cycles model.
module tb_service_window_bank;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int VW = 2*CH + 1 + W;

  logic            clk;
  logic            rst;
  logic [CH-1:0]   start, abort;
  logic [CH*W-1:0] swlen;
  logic [1:0]      rdsel;

  logic [CH-1:0] swstat_a, done_a, swstat_b, done_b;
  logic          any_a, any_b;
  logic [W-1:0]  rdcnt_a, rdcnt_b;

  int checks = 0;
  int errors = 0;

  // Model: remaining open cycles per channel (0 = idle), per bank variant.
  int           m_rem  [2][CH];
  logic [CH-1:0] m_done [2];
  logic [W-1:0]  m_rd   [2];

  service_window_bank #(.CH(CH), .W(W), .RETRIG(1)) dut_a (
    .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .SWLEN(swlen),
    .SWSTAT(swstat_a), .DONE(done_a), .ANY_OPEN(any_a), .RDSEL(rdsel), .RDCNT(rdcnt_a)
  );

  service_window_bank #(.CH(CH), .W(W), .RETRIG(0)) dut_b (
    .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .SWLEN(swlen),
    .SWSTAT(swstat_b), .DONE(done_b), .ANY_OPEN(any_b), .RDSEL(rdsel), .RDCNT(rdcnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit retrig;
      retrig = (k == 0);
      if (rst) begin
        m_rd[k]   = '0;
        m_done[k] = '0;
        for (int i = 0; i < CH; i++) m_rem[k][i] = 0;
      end else begin
        m_rd[k] = W'(m_rem[k][rdsel]);
        for (int i = 0; i < CH; i++) begin
          int len;
          len = int'(swlen[i*W +: W]);
          m_done[k][i] = 1'b0;
          if (abort[i]) begin
            m_rem[k][i] = 0;
          end else if (start[i] && (m_rem[k][i] == 0 || retrig)) begin
            m_rem[k][i] = len;
            if (len == 0) m_done[k][i] = 1'b1;
          end else if (m_rem[k][i] > 0) begin
            m_rem[k][i] = m_rem[k][i] - 1;
            if (m_rem[k][i] == 0) m_done[k][i] = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic logic [VW-1:0] exp_vec(int k);
    logic [CH-1:0] s;
    for (int i = 0; i < CH; i++) s[i] = (m_rem[k][i] == 0);
    return {s, m_done[k], ~&s, m_rd[k]};
  endfunction

  function automatic logic [VW-1:0] got_vec(int k);
    return (k == 0) ? {swstat_a, done_a, any_a, rdcnt_a}
                    : {swstat_b, done_b, any_b, rdcnt_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_len(int i, int v);
    swlen[i*W +: W] = W'(v);
  endtask

  task automatic quiesce();
    start = '0;
    abort = '1;
    tick();
    abort = '0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({swstat_a, done_a, any_a, rdcnt_a} !== {4'hf, 4'h0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_a: got %h expected %h", {swstat_a, done_a, any_a, rdcnt_a}, {4'hf, 4'h0, 1'b0, 8'h00});
    end
    checks++;
    if ({swstat_b, done_b, any_b, rdcnt_b} !== {4'hf, 4'h0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_b: got %h expected %h", {swstat_b, done_b, any_b, rdcnt_b}, {4'hf, 4'h0, 1'b0, 8'h00});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [W-1:0] rd [7];
    logic [W-1:0] exp_rd [7];
    int low = 0, dn = 0;
    exp_rd = '{8'd0, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    quiesce();
    rdsel = 2'd0;
    set_len(0, 5);
    for (int n = 0; n < 10; n++) begin
      start = (n == 0) ? 4'b0001 : 4'b0000;
      tick();
      if (!swstat_a[0]) low++;
      if (done_a[0]) dn++;
      if (n < 7) rd[n] = rdcnt_a;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL basic_vec dut%0d cyc%0d: got %h expected %h", k, n, got_vec(k), exp_vec(k));
        end
      end
    end
    checks++;
    if (low != 5 || dn != 1) begin
      errors++;
      $display("FAIL basic_window: low=%0d done=%0d expected low=5 done=1", low, dn);
    end
    for (int n = 0; n < 7; n++) begin
      checks++;
      if (rd[n] !== exp_rd[n]) begin
        errors++;
        $display("FAIL basic_rdcnt[%0d]: got %0d expected %0d", n, rd[n], exp_rd[n]);
      end
    end
  endtask

  task automatic test_zero_max();
    int low = 0, dn = 0;
    quiesce();
    set_len(0, 0);
    start = 4'b0001;
    tick();
    start = '0;
    checks++;
    if (swstat_a[0] !== 1'b1 || done_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL zero_len: swstat=%b done=%b expected swstat=1 done=1", swstat_a[0], done_a[0]);
    end
    tick();
    checks++;
    if (done_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_pulse: done=%b expected 0", done_a[0]);
    end
    set_len(0, 255);
    for (int n = 0; n < 300; n++) begin
      start = (n == 0) ? 4'b0001 : 4'b0000;
      tick();
      if (!swstat_a[0]) low++;
      if (done_a[0]) dn++;
    end
    checks++;
    if (low != 255 || dn != 1) begin
      errors++;
      $display("FAIL max_len: low=%0d done=%0d expected low=255 done=1", low, dn);
    end
  endtask

  task automatic test_abort();
    int dn = 0;
    quiesce();
    set_len(0, 10);
    for (int n = 0; n < 4; n++) begin
      start = (n == 0) ? 4'b0001 : 4'b0000;
      tick();
      if (done_a[0]) dn++;
    end
    abort = 4'b0001;
    tick();
    abort = '0;
    checks++;
    if (swstat_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL abort_close: swstat=%b expected 1", swstat_a[0]);
    end
    if (done_a[0]) dn++;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (done_a[0]) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL abort_no_done: done pulses=%0d expected 0", dn);
    end
    set_len(0, 3);
    start = 4'b0001;
    abort = 4'b0001;
    tick();
    start = '0;
    abort = '0;
    checks++;
    if (swstat_a[0] !== 1'b1 || done_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_abort: swstat=%b done=%b expected swstat=1 done=0", swstat_a[0], done_a[0]);
    end
  endtask

  task automatic test_retrig();
    int low_a = 0, low_b = 0, dn_a = 0, dn_b = 0;
    quiesce();
    for (int n = 0; n < 20; n++) begin
      start = '0;
      if (n == 0) begin
        set_len(0, 6);
        start = 4'b0001;
      end else if (n == 4) begin
        set_len(0, 3);
        start = 4'b0001;
      end
      tick();
      if (!swstat_a[0]) low_a++;
      if (!swstat_b[0]) low_b++;
      if (done_a[0]) dn_a++;
      if (done_b[0]) dn_b++;
    end
    start = '0;
    checks++;
    if (low_a != 7 || dn_a != 1) begin
      errors++;
      $display("FAIL retrig_on: low=%0d done=%0d expected low=7 done=1", low_a, dn_a);
    end
    checks++;
    if (low_b != 6 || dn_b != 1) begin
      errors++;
      $display("FAIL retrig_off: low=%0d done=%0d expected low=6 done=1", low_b, dn_b);
    end
  endtask

  task automatic test_simultaneous();
    int off_a [CH];
    int off_b [CH];
    int exp_off [CH];
    int fall = 0;
    exp_off = '{3, 5, 1, 2};
    for (int i = 0; i < CH; i++) begin
      off_a[i] = 0;
      off_b[i] = 0;
    end
    quiesce();
    set_len(0, 2);
    set_len(1, 4);
    set_len(2, 0);
    set_len(3, 1);
    start = 4'b1111;
    for (int n = 1; n <= 8; n++) begin
      tick();
      start = '0;
      for (int i = 0; i < CH; i++) begin
        if (done_a[i] && off_a[i] == 0) off_a[i] = n;
        if (done_b[i] && off_b[i] == 0) off_b[i] = n;
      end
      if (!any_a && fall == 0) fall = n;
    end
    for (int i = 0; i < CH; i++) begin
      checks++;
      if (off_a[i] != exp_off[i] || off_b[i] != exp_off[i]) begin
        errors++;
        $display("FAIL simul_done[%0d]: offsets a=%0d b=%0d expected %0d", i, off_a[i], off_b[i], exp_off[i]);
      end
    end
    checks++;
    if (fall != 5) begin
      errors++;
      $display("FAIL simul_any_open: fell at %0d expected 5", fall);
    end
  endtask

  task automatic test_reset_mid();
    quiesce();
    rdsel = 2'd1;
    set_len(0, 8);
    set_len(1, 8);
    start = 4'b0011;
    tick();
    start = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({swstat_a, done_a, rdcnt_a, any_a} !== {4'hf, 4'h0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got %h expected %h", {swstat_a, done_a, rdcnt_a, any_a}, {4'hf, 4'h0, 8'h00, 1'b0});
    end
    set_len(1, 3);
    for (int n = 0; n < 6; n++) begin
      start = (n == 0) ? 4'b0010 : 4'b0000;
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL post_reset_vec dut%0d cyc%0d: got %h expected %h", k, n, got_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < CH; i++) begin
        start[i] = ($urandom_range(0, 5) == 0);
        abort[i] = ($urandom_range(0, 15) == 0);
        set_len(i, int'($urandom_range(0, 12)));
      end
      rdsel = 2'($urandom_range(0, 3));
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL random_vec dut%0d cyc%0d: got %h expected %h", k, n, got_vec(k), exp_vec(k));
        end
      end
    end
    start = '0;
    abort = '0;
  endtask

  initial begin
    rst   = 1'b1;
    start = '0;
    abort = '0;
    swlen = '0;
    rdsel = '0;
    test_reset();
    test_basic();
    test_zero_max();
    test_abort();
    test_retrig();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
